// File: rtl/proc_result_buf_pkg.sv
// Shared definitions for the processed-pixel result buffer.
// Holds the capture FSM state encoding, MMIO word offsets and field bit positions.
// Optional irq feature is controlled by PROC_RESULT_BUF_IRQ_EN in the top module.
package proc_result_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Word offsets selected by mem_addr[3:2]
    localparam logic [1:0] WORD_DATA   = 2'd0;
    localparam logic [1:0] WORD_STATUS = 2'd1;
    localparam logic [1:0] WORD_CTRL   = 2'd2;
    localparam logic [1:0] WORD_COUNT  = 2'd3;

    // DATA fields
    localparam int DATA_STATUS_BIT   = 8;
    localparam int DATA_NONEMPTY_BIT = 9;

    // STATUS fields
    localparam int STATUS_EMPTY_BIT = 16;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_OVF_BIT   = 18;
    localparam int STATUS_STATE_LSB = 19;

    // CTRL fields
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_CLR_BIT     = 2;
    localparam int CTRL_IRQEN_BIT   = 3;

    // COUNT fields
    localparam int COUNT_FRAME_LSB = 16;

endpackage

// File: rtl/result_sync_fifo.sv
// Small synchronous FIFO holding {status, pixel} entries for the result buffer.
// Latency: a push is visible at head/count the cycle after it is presented.
// Push while full is only accepted together with a pop; synchronous clear empties it.
module result_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop on a full FIFO frees the slot the same-cycle push lands in
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    // Next pointer/occupancy; clear overrides any traffic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since empty masks the head
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/proc_result_buffer.sv
// Captures processed pixels into a FIFO drained by the CPU through a 4-word MMIO window.
// Latency: pixel valid in cycle N is visible at DATA/count in N+1; reads are combinational.
// No upstream backpressure: pixels arriving while full are dropped and counted.
// Optional level/done interrupt enabled by defining PROC_RESULT_BUF_IRQ_EN.
module proc_result_buffer
    import proc_result_buf_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 1024,
    parameter int IRQ_LEVEL    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_status,
    input  logic        mem_sel,
    input  logic [3:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic          enable_q, enable_d;
    logic          oneshot_q, oneshot_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   frame_q, frame_d;
    logic          irq_en;

    logic [8:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    logic [1:0]    word;
    logic          wr_en, rd_en, ctrl_wr, clr, pop, capture, push, drop, frame_last;
    logic          unused_ok;

    assign word       = mem_addr[3:2];
    assign wr_en      = mem_sel && (mem_wstrb != 4'h0);
    assign rd_en      = mem_sel && (mem_wstrb == 4'h0);
    assign ctrl_wr    = wr_en && (word == WORD_CTRL);
    assign clr        = ctrl_wr && mem_wdata[CTRL_CLR_BIT];
    assign pop        = rd_en && (word == WORD_DATA) && !fifo_empty;
    assign capture    = (state_q == ST_CAPTURE) && pix_valid && !clr;
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;
    assign frame_last = (frame_q == 16'(FRAME_PIXELS - 1));
    assign unused_ok  = ^{mem_addr[1:0], mem_wdata[31:3]};

    result_sync_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .push_i  (push),
        .wdata_i ({pix_status, pix_in}),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Capture FSM next state plus control, counter and overflow updates
    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        oneshot_d = oneshot_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        frame_d   = frame_q;
        case (state_q)
            ST_IDLE:    if (enable_q) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!enable_q)                             state_d = ST_IDLE;
                else if (capture && frame_last && oneshot_q) state_d = ST_DONE;
            end
            ST_DONE:    if (!enable_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (capture) frame_d = frame_last ? 16'd0 : frame_q + 16'd1;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
        if (ctrl_wr) begin
            enable_d  = mem_wdata[CTRL_EN_BIT];
            oneshot_d = mem_wdata[CTRL_ONESHOT_BIT];
        end
        if (clr) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
            drop_d  = 16'd0;
            frame_d = 16'd0;
        end
    end

    // State, control and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            enable_q  <= 1'b0;
            oneshot_q <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= 16'd0;
            frame_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            oneshot_q <= oneshot_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            frame_q   <= frame_d;
        end
    end

`ifdef PROC_RESULT_BUF_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q, irq_d;

    // Interrupt enable bit and registered level/done interrupt
    always_comb begin
        irq_en_d = ctrl_wr ? mem_wdata[CTRL_IRQEN_BIT] : irq_en_q;
        irq_d    = irq_en_q && ((int'(fifo_count) >= IRQ_LEVEL) || (state_q == ST_DONE));
    end

    // Interrupt registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    // Combinational MMIO read mux; zero when not selected
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_sel) begin
            case (word)
                WORD_DATA: if (!fifo_empty) begin
                    mem_rdata[7:0]               = fifo_head[7:0];
                    mem_rdata[DATA_STATUS_BIT]   = fifo_head[8];
                    mem_rdata[DATA_NONEMPTY_BIT] = 1'b1;
                end
                WORD_STATUS: begin
                    mem_rdata[15:0]                  = 16'(fifo_count);
                    mem_rdata[STATUS_EMPTY_BIT]      = fifo_empty;
                    mem_rdata[STATUS_FULL_BIT]       = fifo_full;
                    mem_rdata[STATUS_OVF_BIT]        = ovf_q;
                    mem_rdata[STATUS_STATE_LSB +: 2] = state_q;
                end
                WORD_CTRL: begin
                    mem_rdata[CTRL_EN_BIT]      = enable_q;
                    mem_rdata[CTRL_ONESHOT_BIT] = oneshot_q;
                    mem_rdata[CTRL_IRQEN_BIT]   = irq_en;
                end
                default: begin
                    mem_rdata[15:0]                 = drop_q;
                    mem_rdata[COUNT_FRAME_LSB +: 16] = frame_q;
                end
            endcase
        end
    end

endmodule
